// File: rtl/ram2_arbiter_pkg.sv
// Shared types and defaults for the RAM port2 arbiter and its helpers.
package ram2_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    // Internal arbiter state, exported so checkers can bind to it.
    typedef struct packed {
        state_t state;
        logic   grant;
        logic   last;
    } dbg_t;

endpackage

// File: rtl/ram2_arbiter_rr_arb2.sv
// Combinational two-request round-robin pick; ties go to the master that
// was not served last.
module rr_arb2
    import ram2_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       any
);

    always_comb begin
        any    = |req;
        gnt_id = M_CPU;
        if (&req) begin
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = M_DMA;
        end
    end

endmodule

// File: rtl/ram2_arbiter.sv
// Shares RAM port2 between the CPU data master and the DMA engine, one
// transaction at a time, with a per-transaction ack watchdog.
module ram2_arbiter
    import ram2_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cpu_stb_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic              cpu_ack_o,
    output logic              cpu_err_o,
    output logic [DATA_W-1:0] cpu_data_o,
    input  logic              dma_stb_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_data_i,
    output logic              dma_ack_o,
    output logic              dma_err_o,
    output logic [DATA_W-1:0] dma_data_o,
    output logic              ram2_stb_o,
    output logic              ram2_we_o,
    output logic [ADDR_W-1:0] ram2_addr_o,
    output logic [DATA_W-1:0] ram2_data_o,
    input  logic              ram2_ack_i,
    input  logic [DATA_W-1:0] ram2_data_i,
    output dbg_t              dbg
);

    // Handshake: a master holds stb until it sees ack or err, then drops it
    // the following cycle. RAM port2 completes a beat when ram2_stb_o and
    // ram2_ack_i are both high; an ack without ram2_stb_o is ignored.

    state_t           state;
    logic             grant;
    logic             last;
    logic [CNT_W-1:0] wd;

    logic pick_id;
    logic pick_any;

    rr_arb2 u_pick (
        .req    ({dma_stb_i, cpu_stb_i}),
        .last   (last),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    logic busy, g_stb, live, wd_hit, done_ack, done_err;

    always_comb begin
        busy     = (state == ST_BUSY);
        g_stb    = (grant == M_DMA) ? dma_stb_i : cpu_stb_i;
        live     = busy && g_stb;
        wd_hit   = (wd == CNT_W'(TIMEOUT - 1));
        done_ack = live && ram2_ack_i;
        // A late ack on the expiry cycle still counts as a completed transfer.
        done_err = live && !ram2_ack_i && wd_hit;
    end

    always_comb begin
        ram2_stb_o  = live && !done_err;
        ram2_we_o   = 1'b0;
        ram2_addr_o = '0;
        ram2_data_o = '0;
        if (live) begin
            ram2_we_o   = (grant == M_DMA) ? dma_we_i   : cpu_we_i;
            ram2_addr_o = (grant == M_DMA) ? dma_addr_i : cpu_addr_i;
            ram2_data_o = (grant == M_DMA) ? dma_data_i : cpu_data_i;
        end
    end

    always_comb begin
        cpu_ack_o  = done_ack && (grant == M_CPU);
        cpu_err_o  = done_err && (grant == M_CPU);
        cpu_data_o = cpu_ack_o ? ram2_data_i : '0;
        dma_ack_o  = done_ack && (grant == M_DMA);
        dma_err_o  = done_err && (grant == M_DMA);
        dma_data_o = dma_ack_o ? ram2_data_i : '0;
    end

    // Every exit from BUSY (ack, timeout, abort) clears wd, so it never wraps.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= ST_IDLE;
            grant <= M_CPU;
            last  <= M_DMA;
            wd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd <= '0;
                    if (pick_any) begin
                        grant <= pick_id;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!g_stb || ram2_ack_i || wd_hit) begin
                        state <= ST_IDLE;
                        last  <= grant;
                        wd    <= '0;
                    end else begin
                        wd <= wd + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg = '{state: state, grant: grant, last: last};

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter: a per-cycle vector table plus hand-written
// sequences for alternation, watchdog expiry, abort and reset.
module tb_ram2_arbiter;
    import ram2_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    // ---------------- clock / reset / DUT ----------------
    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cpu_stb_i, cpu_we_i, dma_stb_i, dma_we_i, ram2_ack_i;
    logic [AW-1:0] cpu_addr_i, dma_addr_i;
    logic [DW-1:0] cpu_data_i, dma_data_i, ram2_data_i;
    logic          cpu_ack_o, cpu_err_o, dma_ack_o, dma_err_o;
    logic          ram2_stb_o, ram2_we_o;
    logic [AW-1:0] ram2_addr_o;
    logic [DW-1:0] cpu_data_o, dma_data_o, ram2_data_o;
    dbg_t          dbg;

    always #5 sys_clk = ~sys_clk;

    ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16), .CNT_W(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cpu_stb_i  (cpu_stb_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_ack_o  (cpu_ack_o),
        .cpu_err_o  (cpu_err_o),
        .cpu_data_o (cpu_data_o),
        .dma_stb_i  (dma_stb_i),
        .dma_we_i   (dma_we_i),
        .dma_addr_i (dma_addr_i),
        .dma_data_i (dma_data_i),
        .dma_ack_o  (dma_ack_o),
        .dma_err_o  (dma_err_o),
        .dma_data_o (dma_data_o),
        .ram2_stb_o (ram2_stb_o),
        .ram2_we_o  (ram2_we_o),
        .ram2_addr_o(ram2_addr_o),
        .ram2_data_o(ram2_data_o),
        .ram2_ack_i (ram2_ack_i),
        .ram2_data_i(ram2_data_i),
        .dbg        (dbg)
    );

    // ---------------- vector types ----------------
    typedef struct packed {
        logic          rst_n;
        logic          cs, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          ds, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          ack;
        logic [DW-1:0] rd;
    } in_t;

    typedef struct packed {
        logic          rs, rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rwd;
        logic          cack, cerr, dack, derr;
        logic [DW-1:0] cdo, ddo;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    function automatic in_t mk_in(logic rst_n, logic cs, logic cw, logic [AW-1:0] ca,
                                  logic [DW-1:0] cd, logic ds, logic dw, logic [AW-1:0] da,
                                  logic [DW-1:0] dd, logic ack, logic [DW-1:0] rd);
        in_t v;
        v.rst_n = rst_n; v.cs = cs; v.cw = cw; v.ca = ca; v.cd = cd;
        v.ds = ds; v.dw = dw; v.da = da; v.dd = dd; v.ack = ack; v.rd = rd;
        return v;
    endfunction

    function automatic out_t mk_out(logic rs, logic rw, logic [AW-1:0] ra, logic [DW-1:0] rwd,
                                    logic cack, logic cerr, logic dack, logic derr,
                                    logic [DW-1:0] cdo, logic [DW-1:0] ddo);
        out_t v;
        v.rs = rs; v.rw = rw; v.ra = ra; v.rwd = rwd;
        v.cack = cack; v.cerr = cerr; v.dack = dack; v.derr = derr;
        v.cdo = cdo; v.ddo = ddo;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input in_t v);
        sys_rst     = v.rst_n;
        cpu_stb_i   = v.cs; cpu_we_i = v.cw; cpu_addr_i = v.ca; cpu_data_i = v.cd;
        dma_stb_i   = v.ds; dma_we_i = v.dw; dma_addr_i = v.da; dma_data_i = v.dd;
        ram2_ack_i  = v.ack;
        ram2_data_i = v.rd;
    endtask

    function automatic out_t sample();
        out_t v;
        v.rs = ram2_stb_o; v.rw = ram2_we_o; v.ra = ram2_addr_o; v.rwd = ram2_data_o;
        v.cack = cpu_ack_o; v.cerr = cpu_err_o; v.dack = dma_ack_o; v.derr = dma_err_o;
        v.cdo = cpu_data_o; v.ddo = dma_data_o;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_out(input string name, input out_t e);
        out_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, a, e);
        end
    endtask

    task automatic check_bits(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, a, e);
        end
    endtask

    // Drive on the falling edge, observe 1ns later, well away from posedge.
    task automatic step(input in_t v);
        @(negedge sys_clk);
        drive(v);
        #1;
    endtask

    in_t  idle_in;
    out_t zero_out;
    vec_t vecs[18];

    initial begin
        idle_in  = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero_out = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // rst_n cs cw ca cd | ds dw da dd | ack rd
        vecs[0]  = '{idle_in, zero_out};
        vecs[1]  = '{mk_in(1, 1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0), zero_out};
        vecs[2]  = '{mk_in(1, 1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0),
                     mk_out(1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{mk_in(1, 1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'hAAAA5555),
                     mk_out(1, 1, 16'h0010, 32'hDEADBEEF, 1, 0, 0, 0, 32'hAAAA5555, 0)};
        vecs[4]  = '{idle_in, zero_out};
        vecs[5]  = '{mk_in(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0030, 32'h11112222, 1, 32'h0BADF00D), zero_out};
        vecs[6]  = '{mk_in(1, 1, 0, 16'h0020, 0, 1, 1, 16'h0030, 32'h11112222, 1, 32'h0BADF00D), zero_out};
        vecs[7]  = '{mk_in(1, 1, 0, 16'h0020, 0, 1, 1, 16'h0030, 32'h11112222, 1, 32'h0BADF00D),
                     mk_out(1, 0, 16'h0020, 0, 1, 0, 0, 0, 32'h0BADF00D, 0)};
        vecs[8]  = '{mk_in(1, 0, 0, 0, 0, 1, 1, 16'h0030, 32'h11112222, 1, 32'h0BADF00D), zero_out};
        vecs[9]  = '{mk_in(1, 0, 0, 0, 0, 1, 1, 16'h0030, 32'h11112222, 1, 32'h0000CAFE),
                     mk_out(1, 1, 16'h0030, 32'h11112222, 0, 0, 1, 0, 0, 32'h0000CAFE)};
        vecs[10] = '{idle_in, zero_out};
        vecs[11] = '{mk_in(1, 0, 0, 0, 0, 1, 0, 16'h0040, 32'h77, 0, 0), zero_out};
        vecs[12] = '{mk_in(1, 0, 0, 0, 0, 1, 0, 16'h0040, 32'h77, 0, 0),
                     mk_out(1, 0, 16'h0040, 32'h77, 0, 0, 0, 0, 0, 0)};
        vecs[13] = '{mk_in(1, 0, 0, 0, 0, 1, 0, 16'h0040, 32'h77, 1, 32'h55),
                     mk_out(1, 0, 16'h0040, 32'h77, 0, 0, 1, 0, 0, 32'h55)};
        vecs[14] = '{mk_in(1, 1, 1, 16'h0050, 32'h99, 0, 0, 0, 0, 0, 0), zero_out};
        vecs[15] = '{mk_in(1, 1, 1, 16'h0050, 32'h99, 0, 0, 0, 0, 0, 0),
                     mk_out(1, 1, 16'h0050, 32'h99, 0, 0, 0, 0, 0, 0)};
        vecs[16] = '{mk_in(1, 0, 1, 16'h0050, 32'h99, 0, 0, 0, 0, 1, 32'h66), zero_out};
        vecs[17] = '{idle_in, zero_out};

        // Reset held with both masters requesting and RAM acking: all quiet.
        drive(mk_in(0, 1, 1, 16'h0010, 32'hDEADBEEF, 1, 1, 16'h0020, 32'h1, 1, 32'hFFFFFFFF));
        #1;
        check_out("reset_hold_0", zero_out);
        @(negedge sys_clk); #1;
        check_out("reset_hold_1", zero_out);
        @(negedge sys_clk); #1;
        check_out("reset_hold_2", zero_out);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].in);
            check_out($sformatf("vec_%0d", i), vecs[i].exp);
        end

        // Fresh reset so CPU wins the first tie, then eight back-to-back transfers.
        step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) exp_q.push_back(i[0] ? M_DMA : M_CPU);
        begin
            int got;
            got = 0;
            step(mk_in(1, 1, 1, 16'h0100, 32'hC0, 1, 1, 16'h0200, 32'hD0, 1, 0));
            for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
                if (cpu_ack_o && dma_ack_o) begin
                    checks++;
                    errors++;
                    $display("FAIL alt_both_ack got cpu=1 dma=1 expected one");
                end else if (cpu_ack_o || dma_ack_o) begin
                    logic exp_id;
                    exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                    check_bits($sformatf("alt_grant_%0d", got), {31'd0, dma_ack_o}, {31'd0, exp_id});
                    got++;
                end
                if (got < 8) begin
                    @(negedge sys_clk); #1;
                end
            end
            check_bits("alt_count", got, 8);
        end
        step(idle_in);
        check_out("alt_drain", zero_out);

        // DMA read with RAM silent: err on the 16th BUSY cycle only.
        step(mk_in(1, 0, 0, 0, 0, 1, 0, 16'h0100, 0, 0, 0));
        check_out("to_idle", zero_out);
        for (int k = 1; k <= 16; k++) begin
            @(negedge sys_clk); #1;
            if (k == 1) check_bits("to_addr", {16'd0, ram2_addr_o}, 32'h0100);
            check_bits($sformatf("to_cyc_%0d", k), {29'd0, ram2_stb_o, dma_err_o, dma_ack_o},
                       (k < 16) ? 32'b100 : 32'b010);
        end
        step(idle_in);
        check_bits("to_back_idle", {31'd0, dbg.state}, {31'd0, ST_IDLE});

        // CPU read acked exactly on the expiry cycle: ack wins.
        step(mk_in(1, 1, 0, 16'h0200, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            @(negedge sys_clk);
            if (k == 16) begin
                ram2_ack_i  = 1'b1;
                ram2_data_i = 32'h12345678;
            end
            #1;
            check_bits($sformatf("ackto_cyc_%0d", k), {29'd0, ram2_stb_o, cpu_ack_o, cpu_err_o},
                       (k < 16) ? 32'b100 : 32'b110);
        end
        check_bits("ackto_data", cpu_data_o, 32'h12345678);
        step(idle_in);
        check_out("ackto_drain", zero_out);

        // CPU abandons its request mid-BUSY while RAM acks: nothing forwarded.
        step(mk_in(1, 1, 1, 16'h0300, 32'h3, 0, 0, 0, 0, 0, 0));
        @(negedge sys_clk); #1;
        check_bits("abort_busy", {31'd0, ram2_stb_o}, 32'd1);
        step(mk_in(1, 0, 1, 16'h0300, 32'h3, 0, 0, 0, 0, 1, 32'h44));
        check_bits("abort_stb_ack", {30'd0, ram2_stb_o, cpu_ack_o}, 32'd0);
        step(idle_in);
        check_bits("abort_idle", {31'd0, dbg.state}, {31'd0, ST_IDLE});

        // Reset pulse during DMA BUSY, then a CPU request must be served.
        step(mk_in(1, 0, 0, 0, 0, 1, 1, 16'h0500, 32'h5, 0, 0));
        @(negedge sys_clk); #1;
        check_bits("rst_dma_busy", {31'd0, ram2_stb_o}, 32'd1);
        step(mk_in(0, 0, 0, 0, 0, 1, 1, 16'h0500, 32'h5, 1, 32'h88));
        check_bits("rst_quiet", {29'd0, ram2_stb_o, dma_ack_o, dma_err_o}, 32'd0);
        check_bits("rst_state", {31'd0, dbg.state}, {31'd0, ST_IDLE});
        step(mk_in(1, 1, 0, 16'h0400, 0, 0, 0, 0, 0, 0, 0));
        check_out("rst_then_idle", zero_out);
        @(negedge sys_clk);
        ram2_ack_i  = 1'b1;
        ram2_data_i = 32'h0000ABCD;
        #1;
        check_bits("rst_cpu_grant", {31'd0, dbg.grant}, {31'd0, M_CPU});
        check_out("rst_cpu_xfer", mk_out(1, 0, 16'h0400, 0, 1, 0, 0, 0, 32'h0000ABCD, 0));
        step(idle_in);
        check_out("final_idle", zero_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
